segway_math_pipe: RTL
=====================

# segway_math_pipe

Parametrised, pipelined successor to the Segway balance-math datapath. It converts the PID controller output, soft-start timer, steering pot and enables into saturated signed left/right motor speed commands. Over the current single-cycle math it adds a valid handshake, a per-wheel slew-rate limiter and a persistence-filtered too_fast flag. It sits between the PID block and the motor-drive/PWM stage.

## Interface
- W, 12: width of PID_cntrl and lft_spd/rght_spd; internal torque width is W+1.
- MIN_DUTY, 13'h3C0: deadband offset added outside the low-torque band; sign-extended to W+1.
- LOW_TORQUE_BAND, 8'h3C: magnitude threshold between gain zone and offset zone.
- GAIN_MULT, 6'h10: gain-zone multiplier, unsigned.
- SLEW_STEP, 0: max per-sample output change; 0 = limiter bypassed.
- FAST_THRESH, 1792: signed speed above which a sample counts as fast.
- FAST_CNT, 1: consecutive fast samples needed to raise too_fast; range 1..255.
- clk  in  1  system clock; all registers on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- vld_in  in  1  input sample valid; may be high every cycle; no backpressure.
- PID_cntrl  in  W  signed PID output.
- ss_tmr  in  8  unsigned soft-start scale.
- steer_pot  in  12  unsigned steering pot reading.
- en_steer  in  1  steering enable.
- pwr_up  in  1  power-up; 0 forces zero speed.
- vld_out  out  1  one-cycle pulse when new speeds are presented.
- lft_spd  out  W  signed left speed; held between updates.
- rght_spd  out  W  signed right speed; held between updates.
- too_fast  out  1  registered over-speed flag.

## Operation
- Stage 1 (captured when vld_in=1):
  - PID_ss = (PID_cntrl × {0,ss_tmr}) >>> 8, sign-extended to W+1.
  - steer: clip steer_pot to [0x200, 0xE00], subtract 0x7FF, arithmetic >>> 4, multiply by 3, sign-extend to W+1.
  - en_steer and pwr_up are captured with the sample.
- Stage 2:
  - lft_torque = PID_ss + steer and rght_torque = PID_ss − steer when en_steer=1; otherwise both equal PID_ss. Result is W+1 bits.
- Stage 3, per wheel:
  - If |torque| > LOW_TORQUE_BAND: shaped = torque ± MIN_DUTY, with the sign of torque.
  - Otherwise: shaped = torque × GAIN_MULT, truncated to W+1 bits.
  - Saturate shaped to W bits signed: max 2^(W−1)−1, min −2^(W−1). This value is the target.
- Output stage, updated only on a stage-3 valid:
  - If the captured pwr_up=0: lft_spd = rght_spd = 0 immediately, no slew. The sample is not fast.
  - Else if SLEW_STEP=0: output = target.
  - Else: d = target − output, computed in W+1 bits. If d > SLEW_STEP, output += SLEW_STEP. If d < −SLEW_STEP, output −= SLEW_STEP. Otherwise output = target.
  - fast = (new lft_spd > FAST_THRESH) or (new rght_spd > FAST_THRESH), signed compare; the positive direction only.
  - If fast: cnt = min(cnt+1, FAST_CNT) and too_fast = (new cnt == FAST_CNT).
  - If not fast: cnt = 0 and too_fast = 0.
- Stages without a valid sample hold their contents. Valid bits advance every cycle.

## Timing
- Reset (rst_n=0, asynchronous): all pipeline registers, valid bits, cnt, lft_spd, rght_spd, too_fast and vld_out go to 0.
- Latency: vld_in sampled high at edge N produces vld_out high for the single cycle after edge N+2, with the new outputs valid in that same cycle.
- Throughput: one sample per cycle. Back-to-back samples are each slewed and counted independently.
- too_fast and cnt update only at edges where vld_out is asserted.
- Reset asserted mid-stream discards all in-flight samples. The first vld_out after release reflects only samples taken after release.
- Simultaneous pwr_up=0 and fast condition: pwr_up wins; outputs are 0, cnt and too_fast clear.

## Test plan
- Nominal, SLEW_STEP=0: PID_cntrl=0x400, ss_tmr=0xFF, en_steer=0, pwr_up=1 → after 3 cycles vld_out pulses; lft_spd = rght_spd = 0x7BC (1980); too_fast=1.
- Gain zone: PID_cntrl=0x020 → ±0x1F0 (496). PID_cntrl=−32, ss_tmr=0xFF → PID_ss=−32 → 0xE00 (−512). too_fast=0 in both cases.
- Steering: PID_cntrl=0, ss_tmr=0xFF, steer_pot=0xFFF, en_steer=1 → lft_spd=1248, rght_spd=−1248. Same inputs with en_steer=0 → both 0.
- Saturation: PID_cntrl=0x7FF, ss_tmr=0xFF → both outputs 0x7FF. PID_cntrl=0x800 → both 0x800.
- Slew, SLEW_STEP=256, FAST_CNT=3: repeat the nominal sample every cycle → outputs 256, 512 … 1792, then 1980 on the 8th vld_out. too_fast rises on the 10th vld_out. Dropping pwr_up → outputs 0 and too_fast=0 on the next vld_out.
- Reset mid-stream: assert rst_n low while two samples are in flight → no vld_out after release until new vld_in; all outputs read 0.

Source files
------------

// File: rtl/segway_math_pipe.sv
// -----------------------------------------------------------------------------
// segway_math_pipe
//   Pipelined balance-math datapath. It turns the PID output, the soft-start
//   scale, the steering pot and the enables into saturated, slew-limited,
//   signed left/right motor speed commands, and raises a persistence-filtered
//   over-speed flag.
//
//   Pipeline: stage 1 register (soft-start scale, steering term), stage 2
//   register (per-wheel torque), stage 3 combinational shaping and saturation
//   feeding the output register (slew limit, speeds, too_fast counter).
//   A sample taken at edge N is presented in the cycle after edge N+2.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   vld_in     input sample valid (no backpressure)
//   PID_cntrl  signed PID output, W bits
//   ss_tmr     unsigned soft-start scale
//   steer_pot  unsigned steering pot reading
//   en_steer   steering enable
//   pwr_up     power-up; 0 forces zero speed
//   vld_out    one-cycle pulse when new speeds are presented
//   lft_spd    signed left speed, held between updates
//   rght_spd   signed right speed, held between updates
//   too_fast   registered over-speed flag
// -----------------------------------------------------------------------------
module segway_math_pipe #(
  parameter int          W               = 12,
  parameter logic [12:0] MIN_DUTY        = 13'h3C0,
  parameter logic [7:0]  LOW_TORQUE_BAND = 8'h3C,
  parameter logic [5:0]  GAIN_MULT       = 6'h10,
  parameter int          SLEW_STEP       = 0,
  parameter int          FAST_THRESH     = 1792,
  parameter int          FAST_CNT        = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_in,
  input  logic [W-1:0] PID_cntrl,
  input  logic [7:0]   ss_tmr,
  input  logic [11:0]  steer_pot,
  input  logic         en_steer,
  input  logic         pwr_up,
  output logic         vld_out,
  output logic [W-1:0] lft_spd,
  output logic [W-1:0] rght_spd,
  output logic         too_fast
);

  localparam int TW = W + 1;  // torque width

  // Shaping constants are carried one bit wider than the torque so that
  // |torque| and torque +/- MIN_DUTY never wrap before saturation.
  localparam logic signed [TW:0] MDUTY_X = (TW+1)'($signed(MIN_DUTY));
  localparam logic signed [TW:0] LTB_X   = (TW+1)'($signed({1'b0, LOW_TORQUE_BAND}));
  localparam logic signed [TW:0] SAT_MAX = (TW+1)'((2 ** (W - 1)) - 1);
  localparam logic signed [TW:0] SAT_MIN = (TW+1)'(-(2 ** (W - 1)));
  localparam logic [7:0]         FC      = 8'(FAST_CNT);

  // ---------------------------------------------------------------- stage 1
  logic signed [W+8:0]  pid_prod;
  logic signed [TW-1:0] pid_ss_w;
  logic [11:0]          steer_clip;
  logic signed [13:0]   steer_ctr;
  logic signed [13:0]   steer_scl;
  logic signed [TW-1:0] steer_w;

  // ss_tmr is treated as unsigned by prefixing a zero sign bit.
  assign pid_prod   = (W+9)'($signed(PID_cntrl)) * (W+9)'($signed({1'b0, ss_tmr}));
  assign pid_ss_w   = TW'(pid_prod >>> 8);

  assign steer_clip = (steer_pot < 12'h200) ? 12'h200 :
                      (steer_pot > 12'hE00) ? 12'hE00 : steer_pot;
  assign steer_ctr  = $signed({2'b00, steer_clip}) - 14'sd2047;
  assign steer_scl  = (steer_ctr >>> 4) * 14'sd3;
  assign steer_w    = TW'(steer_scl);

  logic                 v1_reg;
  logic signed [TW-1:0] pid_ss_reg;
  logic signed [TW-1:0] steer_reg;
  logic                 en1_reg;
  logic                 pwr1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg     <= 1'b0;
      pid_ss_reg <= '0;
      steer_reg  <= '0;
      en1_reg    <= 1'b0;
      pwr1_reg   <= 1'b0;
    end else begin
      v1_reg <= vld_in;
      if (vld_in) begin
        pid_ss_reg <= pid_ss_w;
        steer_reg  <= steer_w;
        en1_reg    <= en_steer;
        pwr1_reg   <= pwr_up;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic                 v2_reg;
  logic signed [TW-1:0] lft_trq_reg;
  logic signed [TW-1:0] rght_trq_reg;
  logic                 pwr2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_reg       <= 1'b0;
      lft_trq_reg  <= '0;
      rght_trq_reg <= '0;
      pwr2_reg     <= 1'b0;
    end else begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        lft_trq_reg  <= en1_reg ? pid_ss_reg + steer_reg : pid_ss_reg;
        rght_trq_reg <= en1_reg ? pid_ss_reg - steer_reg : pid_ss_reg;
        pwr2_reg     <= pwr1_reg;
      end
    end
  end

  // ------------------------------------------- stage 3 + slew, per wheel
  logic signed [W-1:0] lft_next;
  logic signed [W-1:0] rght_next;
  logic [1:0]          fast_w;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_wheel
      logic signed [TW-1:0] trq;
      logic signed [W-1:0]  spd_cur;
      logic signed [TW+6:0] gain_prod;
      logic signed [TW:0]   trq_x;
      logic signed [TW:0]   mag;
      logic signed [TW:0]   shaped;
      logic signed [W-1:0]  target;
      logic signed [TW-1:0] diff;
      logic signed [W-1:0]  spd_next;
      logic                 fast;

      assign trq     = (gi == 0) ? lft_trq_reg : rght_trq_reg;
      assign spd_cur = (gi == 0) ? $signed(lft_spd) : $signed(rght_spd);

      always_comb begin
        trq_x     = (TW+1)'(trq);
        mag       = trq_x[TW] ? -trq_x : trq_x;
        gain_prod = (TW+7)'(trq) * (TW+7)'($signed({1'b0, GAIN_MULT}));

        // Offset zone pushes past the motor deadband; gain zone keeps small
        // torques proportional (product truncated to torque width).
        if (mag > LTB_X)
          shaped = trq_x[TW] ? trq_x - MDUTY_X : trq_x + MDUTY_X;
        else
          shaped = (TW+1)'($signed(TW'(gain_prod)));

        if (shaped > SAT_MAX)
          target = SAT_MAX[W-1:0];
        else if (shaped < SAT_MIN)
          target = SAT_MIN[W-1:0];
        else
          target = shaped[W-1:0];

        diff = TW'(target) - TW'(spd_cur);

        if (!pwr2_reg)
          spd_next = '0;
        else if (SLEW_STEP == 0)
          spd_next = target;
        else if (int'(diff) > SLEW_STEP)
          spd_next = spd_cur + W'(SLEW_STEP);
        else if (int'(diff) < -SLEW_STEP)
          spd_next = spd_cur - W'(SLEW_STEP);
        else
          spd_next = target;

        // Powered-down samples never count as fast.
        fast = pwr2_reg && (int'(spd_next) > FAST_THRESH);
      end

      if (gi == 0) begin : g_lft
        assign lft_next = spd_next;
      end else begin : g_rght
        assign rght_next = spd_next;
      end
      assign fast_w[gi] = fast;
    end
  endgenerate

  // ---------------------------------------------------------- output stage
  logic [7:0] cnt_reg;
  logic [7:0] cnt_next;
  logic       too_fast_next;

  always_comb begin
    cnt_next      = '0;
    too_fast_next = 1'b0;
    if (|fast_w) begin
      cnt_next      = (cnt_reg >= FC) ? FC : cnt_reg + 8'd1;
      too_fast_next = (cnt_next == FC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out  <= 1'b0;
      lft_spd  <= '0;
      rght_spd <= '0;
      cnt_reg  <= '0;
      too_fast <= 1'b0;
    end else begin
      vld_out <= v2_reg;
      if (v2_reg) begin
        lft_spd  <= lft_next;
        rght_spd <= rght_next;
        cnt_reg  <= cnt_next;
        too_fast <= too_fast_next;
      end
    end
  end

endmodule
